// File: rtl/lrhls_product_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// lrhls_acc_pkg
// Shared widths, types and constants for the LRHLS product accumulator.
//   PROD_W_DFLT / ACC_W_DFLT / CNT_W_DFLT : default widths
//   prod_t / acc_t                         : signed product / sum types
//   acc_state_e                            : group FSM state (IDLE, RUN)
//   ACC_MAX / ACC_MIN                      : signed limits of acc_t
// -----------------------------------------------------------------------------
package lrhls_acc_pkg;

  localparam int unsigned PROD_W_DFLT = 36;
  localparam int unsigned ACC_W_DFLT  = 44;
  localparam int unsigned CNT_W_DFLT  = 4;

  typedef logic signed [PROD_W_DFLT-1:0] prod_t;
  typedef logic signed [ACC_W_DFLT-1:0]  acc_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } acc_state_e;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DFLT-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DFLT-1){1'b0}}};

  // Sign-extend a default-width product to the default accumulator width.
  function automatic acc_t sext_prod(input prod_t p);
    return acc_t'(p);
  endfunction

endpackage : lrhls_acc_pkg

// File: rtl/lrhls_product_accumulator_if.sv
// -----------------------------------------------------------------------------
// lrhls_product_accumulator_if
// Product input stream and group-sum output stream of the accumulator.
//   s_prod/s_last/s_valid/s_ready : signed product stream (upstream side)
//   m_sum/m_count/m_ovf/m_valid/m_ready : group result stream (downstream side)
// Modports: slave = accumulator, master = the environment driving it.
// -----------------------------------------------------------------------------
interface lrhls_product_accumulator_if
  import lrhls_acc_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DFLT,
  parameter int unsigned ACC_W  = ACC_W_DFLT,
  parameter int unsigned CNT_W  = CNT_W_DFLT
) ();

  logic signed [PROD_W-1:0] s_prod;
  logic                     s_last;
  logic                     s_valid;
  logic                     s_ready;

  logic signed [ACC_W-1:0]  m_sum;
  logic [CNT_W-1:0]         m_count;
  logic                     m_ovf;
  logic                     m_valid;
  logic                     m_ready;

  modport slave (
    input  s_prod, s_last, s_valid, m_ready,
    output s_ready, m_sum, m_count, m_ovf, m_valid
  );

  modport master (
    output s_prod, s_last, s_valid, m_ready,
    input  s_ready, m_sum, m_count, m_ovf, m_valid
  );

endinterface : lrhls_product_accumulator_if

// File: rtl/lrhls_product_accumulator_sat_add.sv
// -----------------------------------------------------------------------------
// lrhls_sat_add
// ACC_W-bit signed adder. With LRHLS_ACC_SAT_EN defined the result clamps to
// the signed range and o_ovf flags the clamp; otherwise it wraps and the
// o_ovf port does not exist.
//   i_a, i_b : signed addends
//   o_sum    : signed sum (clamped or wrapped)
//   o_ovf    : clamp occurred (LRHLS_ACC_SAT_EN only)
// -----------------------------------------------------------------------------
module lrhls_sat_add
  import lrhls_acc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DFLT
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
`ifdef LRHLS_ACC_SAT_EN
  output logic                    o_ovf,
`endif
  output logic signed [ACC_W-1:0] o_sum
);

  logic signed [ACC_W-1:0] w_raw;

  assign w_raw = i_a + i_b;

`ifdef LRHLS_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] L_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] L_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic w_ovf;

  // Overflow only when both addends share a sign the raw result lost.
  assign w_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);
  assign o_ovf = w_ovf;
  assign o_sum = w_ovf ? (i_a[ACC_W-1] ? L_MIN : L_MAX) : w_raw;
`else
  assign o_sum = w_raw;
`endif

endmodule : lrhls_sat_add

// File: rtl/lrhls_product_accumulator.sv
// -----------------------------------------------------------------------------
// lrhls_product_accumulator
// Streaming signed accumulator: sums a group of PROD_W-bit products into an
// ACC_W-bit sum and emits sum, term count and overflow flag when the group's
// last product is accepted. One-entry registered output; input is stalled
// whenever that entry is full and not being drained.
// Optional feature macro: LRHLS_ACC_SAT_EN (saturating add + sticky m_ovf).
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset
//   bus      : lrhls_product_accumulator_if.slave (s_* input, m_* output)
// -----------------------------------------------------------------------------
module lrhls_product_accumulator
  import lrhls_acc_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DFLT,
  parameter int unsigned ACC_W  = ACC_W_DFLT,
  parameter int unsigned CNT_W  = CNT_W_DFLT
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  lrhls_product_accumulator_if.slave   bus
);

  acc_state_e              r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_m_sum;
  logic [CNT_W-1:0]        r_m_count;
  logic                    r_m_valid;

  logic                    w_in_xfer;
  logic                    w_out_xfer;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_acc_base;
  logic signed [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0]        w_cnt_base;
  logic [CNT_W-1:0]        w_cnt_next;

  // Input is stalled on every beat while the output entry is full and held.
  assign bus.s_ready = ap_rst_n & (~r_m_valid | bus.m_ready);
  assign w_in_xfer   = bus.s_valid & bus.s_ready;
  assign w_out_xfer  = r_m_valid & bus.m_ready;

  assign w_prod_ext  = ACC_W'(bus.s_prod);

  // A group opens from zero in IDLE regardless of leftover register contents.
  assign w_acc_base  = (r_state == IDLE) ? '0 : r_acc;
  assign w_cnt_base  = (r_state == IDLE) ? '0 : r_cnt;

  // Term counter sticks at all-ones instead of wrapping.
  assign w_cnt_next  = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);

`ifdef LRHLS_ACC_SAT_EN
  logic r_ovf;
  logic r_m_ovf;
  logic w_add_ovf;
  logic w_ovf_next;

  assign w_ovf_next = ((r_state == RUN) & r_ovf) | w_add_ovf;
`endif

  lrhls_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .i_a   (w_acc_base),
    .i_b   (w_prod_ext),
`ifdef LRHLS_ACC_SAT_EN
    .o_ovf (w_add_ovf),
`endif
    .o_sum (w_sum)
  );

  // Group FSM, running accumulator and one-entry output register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_m_sum   <= '0;
      r_m_count <= '0;
      r_m_valid <= 1'b0;
`ifdef LRHLS_ACC_SAT_EN
      r_ovf     <= 1'b0;
      r_m_ovf   <= 1'b0;
`endif
    end else begin
      if (w_out_xfer) begin
        r_m_valid <= 1'b0;
      end
      if (w_in_xfer) begin
        if (bus.s_last) begin
          // Closing beat: publish the group; overrides the drain above.
          r_m_sum   <= w_sum;
          r_m_count <= w_cnt_next;
          r_m_valid <= 1'b1;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_state   <= IDLE;
`ifdef LRHLS_ACC_SAT_EN
          r_m_ovf   <= w_ovf_next;
          r_ovf     <= 1'b0;
`endif
        end else begin
          r_acc     <= w_sum;
          r_cnt     <= w_cnt_next;
          r_state   <= RUN;
`ifdef LRHLS_ACC_SAT_EN
          r_ovf     <= w_ovf_next;
`endif
        end
      end
    end
  end

  assign bus.m_sum   = r_m_sum;
  assign bus.m_count = r_m_count;
  assign bus.m_valid = r_m_valid;

`ifdef LRHLS_ACC_SAT_EN
  assign bus.m_ovf   = r_m_ovf;
`else
  assign bus.m_ovf   = 1'b0;
`endif

endmodule : lrhls_product_accumulator

// File: doc/lrhls_product_accumulator.md
# lrhls_product_accumulator

Streaming signed accumulator that sits directly downstream of the 18×18→36-bit signed product stage in the LRHLS linear-regression datapath. It sums a group of 36-bit products, one per stub of a track candidate, into a wide signed sum such as Σxy or Σx². It emits the sum and term count when the group's last product arrives. Both sides use valid/ready handshakes, so back-pressure from the regression solver propagates to the multiplier feed.

## Interface
- PROD_W, 36, signed product width (input)
- ACC_W, 44, signed accumulator/sum width; must be ≥ PROD_W
- CNT_W, 4, term-counter width
---
- ap_clk  in  1  single clock, rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- s_prod  in  PROD_W  signed product from multiplier stage
- s_last  in  1  marks final product of the group
- s_valid  in  1  s_prod/s_last valid
- s_ready  out  1  block accepts input this cycle
- m_sum  out  ACC_W  signed group sum
- m_count  out  CNT_W  number of products in the group
- m_ovf  out  1  sum saturated during the group
- m_valid  out  1  m_* valid
- m_ready  in  1  consumer accepts output

## Operation
- Input transfer: s_valid & s_ready. Output transfer: m_valid & m_ready.
- s_prod is sign-extended to ACC_W before addition.
- Running state: acc (ACC_W), cnt (CNT_W), ovf (sticky), and a one-entry output register.
- FSM states:
  - IDLE: acc = 0, cnt = 0.
  - RUN: group open.
- Transitions:
  - IDLE→RUN on a non-last transfer.
  - Any last transfer → IDLE, and loads the output register with the final acc+prod, cnt+1 and ovf.
  - A last transfer in IDLE produces a one-term group.
- s_ready = !m_valid | m_ready. Stalling is applied to every input, not only last inputs, so a group never straddles a full output register.
- cnt saturates at 2^CNT_W−1; it never wraps.
- Simultaneous output transfer and last input transfer in the same cycle: the output register reloads with the new group and m_valid stays 1.
- Asynchronous reset mid-group discards the partial sum and any pending output. There is no flush.
- There is no empty group: every group contains ≥1 product.

## Timing
- Reset values: s_ready=0 while ap_rst_n low, then 1. m_valid=0, m_sum=0, m_count=0, m_ovf=0. FSM=IDLE.
- Latency: a last product accepted at cycle t gives m_valid=1 at t+1, with m_sum including that product.
- Throughput: one product per cycle. Back-to-back groups run with no bubble when m_ready=1.
- m_* outputs are registered and held stable while m_valid & !m_ready.
- s_ready is combinational from m_valid/m_ready only.

## Configuration
- LRHLS_ACC_SAT_EN defined:
  - Each addition clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - A clamp sets ovf, sticky until group end; m_ovf reports it.
- Undefined:
  - Two's-complement wrap.
  - m_ovf tied to 0; no overflow logic synthesised.

## Structure
- Package lrhls_acc_pkg holds:
  - PROD_W/ACC_W/CNT_W defaults
  - acc_t and prod_t signed typedefs
  - the FSM state enum (IDLE, RUN)
  - ACC_MAX/ACC_MIN constants
- One sub-module, lrhls_sat_add: ACC_W signed adder returning sum and an overflow flag. Its saturation path is under LRHLS_ACC_SAT_EN.

## Test plan
- Group of products 100, −30, 7 (last), m_ready=1 → one output at last+1: m_sum=77, m_count=3, m_ovf=0.
- Single product −131072×131071 = −17179738112 with last → m_sum=−17179738112, m_count=1.
- m_ready=0 holding a finished group while a new group streams → s_ready=0, first output stable until m_ready=1. Then the second group sums correctly with no lost or duplicated product.
- Back-to-back groups [5,last][9,last] with m_ready=1 → consecutive cycles m_sum=5, then 9, with no bubble.
- SAT_EN, ACC_W=36 (= PROD_W), products 2^35−1 then 1 (last) → m_sum=2^35−1, m_ovf=1. Without the macro: m_sum=−2^35, m_ovf=0.
- ap_rst_n pulsed low after two products of an open group → outputs return to reset values. The next group [4,last] yields m_sum=4, m_count=1.
